// File: rtl/ssd_score_display.sv
// Score-to-seven-segment driver: sequential double-dabble BCD conversion followed by
// a 4-digit multiplexed scan with optional leading-zero blanking and an overflow dot.
module ssd_score_display #(
   parameter int SCAN_BITS = 18,
   parameter bit BLANK_LZ  = 1'b1
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic [15:0] score,
   input  logic        load,
   output logic        busy,
   output logic        overflow,
   output logic [3:0]  anode,
   output logic [6:0]  ssd,
   output logic        dp
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t         state, state_nxt;
   logic [15:0]    bin, bcd, bcd_adj, disp_bcd, pend_val, src, src_clamp;
   logic [4:0]     cnt;
   logic           pending;
   logic [SCAN_BITS-1:0] scan;
   logic [1:0]     digit;
   logic [3:0]     nib;
   logic           blank;
   logic [6:0]     seg;

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load || pending) state_nxt = CONV;
         CONV:    if (cnt == 5'd1)     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A fresh load beats a buffered one
   assign src       = load ? score : pend_val;
   assign src_clamp = (src > 16'd9999) ? 16'd9999 : src;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++)
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
         disp_bcd <= '0;
         pending  <= 1'b0;
         pend_val <= '0;
      end else begin
         case (state)
            IDLE: if (load || pending) begin
               bin      <= src_clamp;
               overflow <= (src > 16'd9999);
               bcd      <= '0;
               cnt      <= 5'd16;
               busy     <= 1'b1;
               pending  <= 1'b0;
            end
            CONV: begin
               {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
               cnt        <= cnt - 5'd1;
            end
            DONE: begin
               disp_bcd <= bcd;
               busy     <= 1'b0;
            end
            default: ;
         endcase
         // Loads arriving mid-conversion are buffered; the latest one wins
         if (state != IDLE && load) begin
            pending  <= 1'b1;
            pend_val <= score;
         end
      end
   end

   assign digit = scan[SCAN_BITS-1 -: 2];
   assign nib   = disp_bcd[digit*4 +: 4];

   always_comb begin
      blank = 1'b0;
      if (BLANK_LZ) begin
         case (digit)
            2'd3: blank = (disp_bcd[15:12] == 4'd0);
            2'd2: blank = (disp_bcd[15:8]  == 8'd0);
            2'd1: blank = (disp_bcd[15:4]  == 12'd0);
            default: blank = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (nib)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         scan  <= '0;
         anode <= 4'b1111;
         ssd   <= 7'b1111111;
         dp    <= 1'b1;
      end else begin
         scan  <= scan + 1'b1;
         anode <= blank ? 4'b1111 : ~(4'b0001 << digit);
         ssd   <= blank ? 7'b1111111 : seg;
         dp    <= ~((digit == 2'd3) && overflow);
      end
   end

endmodule
